// File: rtl/tiger_leap_counter_bank_if.sv
// LEAP handler-side bus: lp_mm register/counter port
// plus the core's counter increment request port.
interface tiger_leap_counter_bank_if #(
  parameter int N2 = 8,
  parameter int FW = 6,
  parameter int CW = 32
) ();
  logic [N2-1:0] lp_mm_addr;
  logic          lp_mm_wren;
  logic [31:0]   lp_mm_wrdata;
  logic [31:0]   lp_mm_rddata;
  logic          cnt_valid;
  logic [FW-1:0] cnt_func;
  logic [CW-1:0] cnt_delta;

  modport master (
    output lp_mm_addr, lp_mm_wren, lp_mm_wrdata,
    output cnt_valid, cnt_func, cnt_delta,
    input  lp_mm_rddata
  );

  modport slave (
    input  lp_mm_addr, lp_mm_wren, lp_mm_wrdata,
    input  cnt_valid, cnt_func, cnt_delta,
    output lp_mm_rddata
  );
endinterface

// File: rtl/tiger_leap_counter_bank.sv
// LEAP profiler config registers and per-function
// saturating counter array with pipelined increments.
module tiger_leap_counter_bank #(
  parameter int N2        = 8,
  parameter int NUM_FUNCS = 64,
  parameter int CW        = 32,
  parameter int TAB_WORDS = 16,
  localparam int FW       = $clog2(NUM_FUNCS)
) (
  input  logic                    clk,
  input  logic                    reset,
  tiger_leap_counter_bank_if.slave bus,
  output logic                    clr_busy,
  output logic [31:0]             cfg_v1,
  output logic [7:0]              cfg_a1,
  output logic [7:0]              cfg_a2,
  output logic [7:0]              cfg_b1,
  output logic [7:0]              cfg_b2,
  output logic [32*TAB_WORDS-1:0] cfg_tab,
  output logic [31:0]             cfg_inc_mask,
  output logic                    cfg_do_hier,
  output logic [31:0]             cfg_init_pc
);

  localparam logic [N2-1:0] A_V1   = N2'('h00);
  localparam logic [N2-1:0] A_HASH = N2'('h01);
  localparam logic [N2-1:0] A_TAB  = N2'('h40);
  localparam logic [N2-1:0] A_INC  = N2'('h80);
  localparam logic [N2-1:0] A_HIER = N2'('h81);
  localparam logic [N2-1:0] A_PC   = N2'('h82);
  localparam logic [N2-1:0] A_CLR  = N2'('hC0);
  localparam logic [N2-1:0] TAB_N  = N2'(TAB_WORDS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [FW-1:0] idx;

  logic [CW-1:0] mem [NUM_FUNCS];

  logic          s1_valid, s2_valid;
  logic [FW-1:0] s1_func, s2_func;
  logic [CW-1:0] s1_delta, s2_delta, s2_old;

  logic [N2-1:0] addr;
  logic [31:0]   wd;
  logic [N2-1:0] tab_off;
  logic          is_tab;
  logic          clr_cmd;
  logic [CW:0]   sum_full;
  logic [CW-1:0] sum;
  logic          fwd;
  logic          mem_we;
  logic [FW-1:0] mem_wa;
  logic [CW-1:0] mem_wd;

  assign addr    = bus.lp_mm_addr;
  assign wd      = bus.lp_mm_wrdata;
  assign tab_off = addr - A_TAB;
  assign is_tab  = tab_off < TAB_N;
  assign clr_cmd = bus.lp_mm_wren && addr == A_CLR && wd[0];

  assign clr_busy = state == CLEAR;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_v1       <= '0;
      cfg_a1       <= '0;
      cfg_a2       <= '0;
      cfg_b1       <= '0;
      cfg_b2       <= '0;
      cfg_tab      <= '0;
      cfg_inc_mask <= 32'd1;
      cfg_do_hier  <= 1'b0;
      cfg_init_pc  <= '0;
    end else if (bus.lp_mm_wren) begin
      unique case (1'b1)
        (addr == A_V1):   cfg_v1 <= wd;
        (addr == A_HASH): {cfg_a1, cfg_a2, cfg_b1, cfg_b2} <= wd;
        is_tab: begin
          for (int k = 0; k < TAB_WORDS; k++)
            if (tab_off == N2'(k))
              cfg_tab[32*k +: 32] <= wd;
        end
        (addr == A_INC):  cfg_inc_mask <= wd;
        (addr == A_HIER): cfg_do_hier  <= wd[0];
        (addr == A_PC):   cfg_init_pc  <= wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
      idx   <= '0;
    end else if (clr_cmd) begin
      state <= CLEAR;
      idx   <= '0;
    end else if (state == CLEAR) begin
      idx <= idx + 1'b1;
      if (&idx)
        state <= IDLE;
    end
  end

  assign sum_full = {1'b0, s2_old} + {1'b0, s2_delta};
  assign sum      = sum_full[CW] ? '1 : sum_full[CW-1:0];
  // S2 has not written yet when S1 reads the same entry
  assign fwd      = s2_valid && s1_func == s2_func;

  always_ff @(posedge clk) begin
    if (!reset || state == CLEAR || clr_cmd) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= bus.cnt_valid;
      s1_func  <= bus.cnt_func;
      s1_delta <= bus.cnt_delta;
      s2_valid <= s1_valid;
      s2_func  <= s1_func;
      s2_delta <= s1_delta;
      s2_old   <= fwd ? sum : mem[s1_func];
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = idx;
    mem_wd = '0;
    if (state == CLEAR) begin
      mem_we = 1'b1;
    end else if (s2_valid) begin
      mem_we = 1'b1;
      mem_wa = s2_func;
      mem_wd = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      bus.lp_mm_rddata <= '0;
    else if (addr[N2-1:FW] == '0)
      bus.lp_mm_rddata <= 32'(mem[addr[FW-1:0]]);
    else
      bus.lp_mm_rddata <= '0;
  end

endmodule

// File: tb/tb_tiger_leap_counter_bank.sv
// Directed bench for tiger_leap_counter_bank:
// config decode, counter reads, increments, clear sweep.
module tb_tiger_leap_counter_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr_busy;
  logic [31:0]  cfg_v1;
  logic [7:0]   cfg_a1, cfg_a2, cfg_b1, cfg_b2;
  logic [511:0] cfg_tab;
  logic [31:0]  cfg_inc_mask;
  logic         cfg_do_hier;
  logic [31:0]  cfg_init_pc;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  logic [31:0] v;

  tiger_leap_counter_bank_if #(.N2(8), .FW(6), .CW(32)) bus ();

  tiger_leap_counter_bank dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .clr_busy     (clr_busy),
    .cfg_v1       (cfg_v1),
    .cfg_a1       (cfg_a1),
    .cfg_a2       (cfg_a2),
    .cfg_b1       (cfg_b1),
    .cfg_b2       (cfg_b2),
    .cfg_tab      (cfg_tab),
    .cfg_inc_mask (cfg_inc_mask),
    .cfg_do_hier  (cfg_do_hier),
    .cfg_init_pc  (cfg_init_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.lp_mm_addr   = a;
    bus.lp_mm_wrdata = d;
    bus.lp_mm_wren   = 1'b1;
    tick();
    bus.lp_mm_wren   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.lp_mm_addr = a;
    tick();
    d = bus.lp_mm_rddata;
  endtask

  task automatic inc(input logic [5:0] f, input logic [31:0] d);
    bus.cnt_valid = 1'b1;
    bus.cnt_func  = f;
    bus.cnt_delta = d;
    tick();
    bus.cnt_valid = 1'b0;
  endtask

  task automatic drain();
    bus.cnt_valid = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    bus.lp_mm_addr   = '0;
    bus.lp_mm_wren   = 1'b0;
    bus.lp_mm_wrdata = '0;
    bus.cnt_valid    = 1'b0;
    bus.cnt_func     = '0;
    bus.cnt_delta    = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;

    chk("rst_busy", 32'(clr_busy), 32'd1);
    chk("rst_v1", cfg_v1, 32'd0);
    chk("rst_inc_mask", cfg_inc_mask, 32'd1);
    chk("rst_hier", 32'(cfg_do_hier), 32'd0);
    chk("rst_rddata", bus.lp_mm_rddata, 32'd0);
    chk("rst_tab0", cfg_tab[31:0], 32'd0);
    cnt = 0;
    while (clr_busy && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("rst_sweep_len", 32'(cnt), 32'd64);

    for (int i = 0; i < 64; i++) begin
      rd(8'(i), v);
      chk($sformatf("rst_cnt%0d", i), v, 32'd0);
    end
    rd(8'h90, v);
    chk("rd_0x90", v, 32'd0);

    wr(8'h00, 32'h11223344);
    chk("v1", cfg_v1, 32'h11223344);
    wr(8'h01, 32'h051C080F);
    wr(8'h43, 32'hDEADBEEF);
    chk("a1", 32'(cfg_a1), 32'h05);
    chk("a2", 32'(cfg_a2), 32'h1C);
    chk("b1", 32'(cfg_b1), 32'h08);
    chk("b2", 32'(cfg_b2), 32'h0F);
    chk("tab3", cfg_tab[127:96], 32'hDEADBEEF);
    chk("tab2", cfg_tab[95:64], 32'd0);
    chk("v1_kept", cfg_v1, 32'h11223344);
    wr(8'h4F, 32'hA5A5A5A5);
    chk("tab15", cfg_tab[511:480], 32'hA5A5A5A5);
    wr(8'h50, 32'h99999999);
    chk("tab15_kept", cfg_tab[511:480], 32'hA5A5A5A5);
    chk("tab0_kept", cfg_tab[31:0], 32'd0);
    wr(8'h80, 32'h0000000C);
    wr(8'h81, 32'h00000003);
    wr(8'h82, 32'h00400100);
    wr(8'h83, 32'hFFFFFFFF);
    chk("inc_mask", cfg_inc_mask, 32'h0000000C);
    chk("do_hier", 32'(cfg_do_hier), 32'd1);
    chk("init_pc", cfg_init_pc, 32'h00400100);
    bus.lp_mm_addr   = 8'h00;
    bus.lp_mm_wrdata = 32'h77777777;
    tick();
    chk("no_wren", cfg_v1, 32'h11223344);

    for (int i = 0; i < 5; i++) inc(6'd3, 32'd2);
    drain();
    rd(8'h03, v);
    chk("cnt3", v, 32'd10);

    for (int i = 0; i < 10; i++) inc((i % 2 == 0) ? 6'd1 : 6'd2, 32'd1);
    drain();
    rd(8'h01, v);
    chk("cnt1", v, 32'd5);
    rd(8'h02, v);
    chk("cnt2", v, 32'd5);

    inc(6'd7, 32'hFFFFFFF0);
    inc(6'd7, 32'h20);
    drain();
    rd(8'h07, v);
    chk("cnt7_sat", v, 32'hFFFFFFFF);
    inc(6'd7, 32'd1);
    drain();
    rd(8'h07, v);
    chk("cnt7_sat_hold", v, 32'hFFFFFFFF);

    bus.cnt_valid    = 1'b1;
    bus.cnt_func     = 6'd9;
    bus.cnt_delta    = 32'd4;
    bus.lp_mm_addr   = 8'h00;
    bus.lp_mm_wrdata = 32'h0000CAFE;
    bus.lp_mm_wren   = 1'b1;
    tick();
    bus.lp_mm_wren   = 1'b0;
    drain();
    chk("v1_simul", cfg_v1, 32'h0000CAFE);
    rd(8'h09, v);
    chk("cnt9_simul", v, 32'd4);

    for (int i = 0; i < 3; i++) inc(6'd5, 32'd7);
    drain();
    wr(8'hC0, 32'h00000002);
    chk("clr_bit0_low", 32'(clr_busy), 32'd0);
    rd(8'h05, v);
    chk("cnt5", v, 32'd21);

    wr(8'hC0, 32'h00000001);
    chk("clr_busy", 32'(clr_busy), 32'd1);
    cnt = 0;
    while (clr_busy && cnt < 200) begin
      bus.cnt_valid = 1'b1;
      bus.cnt_func  = 6'(cnt);
      bus.cnt_delta = 32'd3;
      cnt++;
      tick();
    end
    bus.cnt_valid = 1'b0;
    chk("clr_sweep_len", 32'(cnt), 32'd64);
    drain();
    for (int i = 0; i < 64; i++) begin
      rd(8'(i), v);
      chk($sformatf("clr_cnt%0d", i), v, 32'd0);
    end
    chk("cfg_after_clr", cfg_v1, 32'h0000CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tiger_leap_counter_bank.md
Name: tiger_leap_counter_bank

Overview:
- Downstream neighbour of the LEAP Avalon slave handler. Terminates its lp_mm_* interface.
- Holds the profiler configuration registers: hash V1, A1/A2/B1/B2, hash table tab, inc_mask, do_hier and init_pc.
- Holds the per-function counter array that the LEAP core increments through a pipelined read-modify-write port.
- Returns counter values to the handler with 1-cycle read latency.

Parameters:
- N2, 8, lp_mm address width.
- NUM_FUNCS, 64, counter entries (power of 2, ≤ 2**(N2-1)); FW = log2(NUM_FUNCS).
- CW, 32, counter width.
- TAB_WORDS, 16, number of 32-bit hash-table words.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- lp_mm_addr  in  N2  register/counter address.
- lp_mm_wren  in  1  write strobe.
- lp_mm_wrdata  in  32  write data.
- lp_mm_rddata  out  32  counter read data, registered.
- cnt_valid  in  1  increment request.
- cnt_func  in  FW  function index to increment.
- cnt_delta  in  CW  increment amount.
- clr_busy  out  1  clear sweep in progress.
- cfg_v1  out  32  hash V1.
- cfg_a1, cfg_a2, cfg_b1, cfg_b2  out  8 each  hash constants.
- cfg_tab  out  32*TAB_WORDS  hash table, word k at bits [32k+31:32k].
- cfg_inc_mask  out  32  counter increment option.
- cfg_do_hier  out  1  hierarchical profiling enable.
- cfg_init_pc  out  32  PC of the call to main.

Behaviour:
- Reset (reset==0 at posedge clk):
  - cfg_v1=0, a1/a2/b1/b2=0, cfg_tab=0, cfg_inc_mask=1, cfg_do_hier=0, cfg_init_pc=0, lp_mm_rddata=0.
  - Pipeline valid bits=0.
  - FSM enters CLEAR with sweep index=0.
  - Reset mid-operation aborts any sweep or pending increment and restarts the clear.
- Config writes, decoded only when lp_mm_wren=1, take effect the next cycle:
  - 0x00: V1.
  - 0x01: {A1,A2,B1,B2} = wrdata[31:24], [23:16], [15:8], [7:0].
  - 0x40+k, k<TAB_WORDS: tab word k.
  - 0x80: inc_mask.
  - 0x81: do_hier = wrdata[0].
  - 0x82: init_pc.
  - 0xC0: if wrdata[0]=1, start a clear sweep (restarts if already in CLEAR); no register is updated.
  - Any other address: ignored.
- Reads:
  - lp_mm_rddata <= counter[lp_mm_addr[FW-1:0]] when lp_mm_addr < NUM_FUNCS, else 0. Updated every cycle, 1-cycle latency, no read strobe.
  - Reads return the stored array value. An increment write landing in the same cycle is not forwarded.
- FSM has two states, IDLE and CLEAR.
  - CLEAR: writes 0 to counter[idx] and increments idx each cycle; clr_busy=1.
  - CLEAR → IDLE after idx=NUM_FUNCS-1 is written. A full sweep takes exactly NUM_FUNCS cycles.
  - cnt_valid during CLEAR is dropped, and in-flight pipeline stages are invalidated.
- Increment pipeline (IDLE only):
  - S1: register {func, delta}; array read issues.
  - S2: sum = old + delta, saturating at 2**CW-1; write counter[func]=sum.
  - Throughput is 1 per cycle.
  - Back-to-back increments to the same func: S1 uses S2's sum (forwarding), so no update is lost.
  - Simultaneous increment and config write are independent.
- Array is single write port; synthesizable as RAM with a registered read address.

Test Plan:
- Reset low 1 cycle, then high → clr_busy=1 for exactly 64 cycles. Then reads of addr 0..63 return 0, read of addr 0x90 returns 0, cfg_inc_mask=1.
- Write 0x01←0x051C080F and 0x43←0xDEADBEEF → cfg_a1=0x05, cfg_b2=0x0F, cfg_tab[127:96]=0xDEADBEEF. V1 is unchanged.
- cnt_valid for 5 consecutive cycles, func=3, delta=2 → counter[3]=10. Read addr 3 → rddata=10 one cycle later.
- Interleave func=1 and func=2 with delta=1 for 10 cycles → both counters=5.
- Preload counter[7]=0xFFFFFFF0, then delta=0x20 → counter[7]=0xFFFFFFFF (saturated).
- Accumulate counts, write 0xC0←1, and drive cnt_valid during the sweep → all counters=0 after 64 cycles. Increments issued during the sweep are absent.
